// File: rtl/dip_switch_reader_pkg.sv
// Shared definitions for the DIP switch reader: event FSM encoding,
// default debounce length and the debounce counter width helper.
package dip_switch_reader_pkg;

  // 20 ms at 50 MHz
  localparam int DIP_DEB_DEFAULT = 1_000_000;

  typedef enum logic {
    DIP_IDLE = 1'b0,
    DIP_PEND = 1'b1
  } dip_state_t;

  function automatic int dip_cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/dip_sync_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer for the active-low DIP bank.
// upd is high in the cycle whose closing edge loads a new sw_state.
module dip_sync_debounce
  import dip_switch_reader_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DIP_DEB_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ckey,
  output logic [WIDTH-1:0] sw_state,
  output logic             upd
);

  localparam int            CW       = dip_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] sync_on;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;
  logic             stable;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_LAST) ? v : v + CW'(1);
  endfunction

  assign sync_on = ~sync_p1;
  assign stable  = (sync_on == cand) && (cnt == CNT_LAST);
  assign upd     = stable && (cand != sw_state);

  // Stage p0/p1: pins are asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= ckey;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: a glitch on any bit restarts the shared counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand     <= '1;
      cnt      <= '0;
      sw_state <= '0;
    end else if (sync_on != cand) begin
      cand <= sync_on;
      cnt  <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= sat_inc(cnt);
    end else if (cand != sw_state) begin
      sw_state <= cand;
    end
  end

endmodule

// File: rtl/dip_switch_reader.sv
// DIP switch reader: debounced state plus valid/ready change events with a
// cumulative change mask. Optional LED mirror enabled by DIP_LED_MIRROR_EN.
module dip_switch_reader
  import dip_switch_reader_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DIP_DEB_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ckey,
  output logic [WIDTH-1:0] sw_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] evt_mask,
  output logic             overrun,
  input  logic             overrun_clr
`ifdef DIP_LED_MIRROR_EN
  ,
  output logic [WIDTH-1:0] led
`endif
);

  dip_state_t       state;
  dip_state_t       state_nxt;
  logic [WIDTH-1:0] rep;
  logic             upd;
  logic             offer;
  logic             accept;

  dip_sync_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .ckey    (ckey),
    .sw_state(sw_state),
    .upd     (upd)
  );

  assign offer  = (state == DIP_IDLE) && (sw_state != rep);
  assign accept = (state == DIP_PEND) && evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIP_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIP_IDLE: if (offer)     state_nxt = DIP_PEND;
      DIP_PEND: if (evt_ready) state_nxt = DIP_IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state == DIP_PEND);
  end

  // Event payload is frozen while pending; later changes coalesce into the next mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_data <= '0;
      evt_mask <= '0;
      rep      <= '0;
    end else if (offer) begin
      evt_data <= sw_state;
      evt_mask <= sw_state ^ rep;
    end else if (accept) begin
      rep <= evt_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            overrun <= 1'b0;
    else if (upd && state == DIP_PEND)  overrun <= 1'b1;
    else if (overrun_clr)               overrun <= 1'b0;
  end

`ifdef DIP_LED_MIRROR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= '1;
    else     led <= ~sw_state;
  end
`endif

endmodule

// File: tb/tb_dip_switch_reader.sv
// Bench for dip_switch_reader (WIDTH=4, DEBOUNCE_CYCLES=8): directed scenarios
// plus random pin/ready traffic against a sliding-window reference model.
module tb_dip_switch_reader;

  localparam int W  = 4;
  localparam int N  = 8;
  localparam int HL = N + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ckey;
  logic [W-1:0] sw_state;
  logic         evt_valid;
  logic         evt_ready;
  logic [W-1:0] evt_data;
  logic [W-1:0] evt_mask;
  logic         overrun;
  logic         overrun_clr;
`ifdef DIP_LED_MIRROR_EN
  logic [W-1:0] led;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dip_switch_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .ckey       (ckey),
    .sw_state   (sw_state),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .evt_mask   (evt_mask),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`ifdef DIP_LED_MIRROR_EN
    ,
    .led        (led)
`endif
  );

  // Reference model: h[i] holds the active-high pin value sampled i+1 edges ago.
  // A value reaches the output once N+1 consecutive samples, ending two edges back, agree.
  logic [W-1:0] h [0:HL-1];
  logic [W-1:0] m_sw, m_data, m_mask, m_rep;
  logic         m_valid, m_over, m_upd;

  function automatic logic win_ok(input logic [W-1:0] hh [0:HL-1]);
    for (int i = 2; i <= N + 1; i++)
      if (hh[i] !== hh[1]) return 1'b0;
    return 1'b1;
  endfunction

  always_comb m_upd = win_ok(h) && (h[1] != m_sw);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HL; i++) h[i] <= '0;
      m_sw <= '0; m_data <= '0; m_mask <= '0; m_rep <= '0;
      m_valid <= 1'b0; m_over <= 1'b0;
    end else begin
      h[0] <= ~ckey;
      for (int i = 1; i < HL; i++) h[i] <= h[i-1];
      if (m_upd) m_sw <= h[1];
      if (!m_valid && m_sw != m_rep) begin
        m_valid <= 1'b1; m_data <= m_sw; m_mask <= m_sw ^ m_rep;
      end else if (m_valid && evt_ready) begin
        m_valid <= 1'b0; m_rep <= m_data;
      end
      if (m_upd && m_valid)  m_over <= 1'b1;
      else if (overrun_clr)  m_over <= 1'b0;
    end
  end

  logic [13:0] obs, exp_obs;
  assign obs     = {sw_state, evt_valid, evt_data, evt_mask, overrun};
  assign exp_obs = {m_sw, m_valid, m_data, m_mask, m_over};

  task automatic test_reset();
    rst = 1'b1; ckey = 4'hF; evt_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sw_state, evt_valid, overrun} !== 6'b0)
      $display("FAIL reset_values actual=%b required=%b", {sw_state, evt_valid, overrun}, 6'b0);
`ifdef DIP_LED_MIRROR_EN
    checks++;
    if (led !== 4'hF) $display("FAIL reset_led actual=%h required=f", led);
    if (led !== 4'hF) errors++;
`endif
    if ({sw_state, evt_valid, overrun} !== 6'b0) errors++;
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if ({sw_state, evt_valid, overrun} !== 6'b0) begin
        errors++;
        $display("FAIL idle_hold cycle=%0d actual=%b required=%b", c, {sw_state, evt_valid, overrun}, 6'b0);
      end
    end
  endtask

  task automatic test_clean();
    logic [W-1:0] exp_sw;
    evt_ready = 1'b1;
    ckey = 4'b1110;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      exp_sw = (e >= 11) ? 4'b0001 : 4'b0000;
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL clean_model edge=%0d actual=%h required=%h", e, obs, exp_obs);
      end
      checks++;
      if (sw_state !== exp_sw) begin
        errors++; $display("FAIL clean_sw edge=%0d actual=%b required=%b", e, sw_state, exp_sw);
      end
      checks++;
      if (evt_valid !== (e == 12)) begin
        errors++; $display("FAIL clean_valid edge=%0d actual=%b required=%b", e, evt_valid, (e == 12));
      end
      if (e == 12) begin
        checks++;
        if ({evt_data, evt_mask} !== 8'h11) begin
          errors++; $display("FAIL clean_payload actual=%h required=11", {evt_data, evt_mask});
        end
      end
`ifdef DIP_LED_MIRROR_EN
      checks++;
      if (led !== ((e >= 12) ? 4'b1110 : 4'b1111)) begin
        errors++; $display("FAIL led_mirror edge=%0d actual=%b required=%b", e, led, ((e >= 12) ? 4'b1110 : 4'b1111));
      end
`endif
    end
  endtask

  task automatic test_bounce();
    int evts;
    int len;
    logic [W-1:0] exp_sw;
    evt_ready = 1'b1;
    ckey = 4'b1111;
    repeat (16) @(negedge clk);
    evts = 0;
    for (int s = 0; s < 7; s++) begin
      ckey = {3'b111, s[0]};
      len = (s == 6) ? 20 : 3;
      for (int c = 1; c <= len; c++) begin
        @(negedge clk);
        if (evt_valid) evts++;
        exp_sw = (s == 6 && c >= 11) ? 4'b0001 : 4'b0000;
        checks++;
        if (obs !== exp_obs) begin
          errors++; $display("FAIL bounce_model seg=%0d c=%0d actual=%h required=%h", s, c, obs, exp_obs);
        end
        checks++;
        if (sw_state !== exp_sw) begin
          errors++; $display("FAIL bounce_sw seg=%0d c=%0d actual=%b required=%b", s, c, sw_state, exp_sw);
        end
      end
    end
    checks++;
    if (evts != 1) begin
      errors++; $display("FAIL bounce_event_count actual=%0d required=1", evts);
    end
  endtask

  task automatic test_overrun();
    logic seen;
    evt_ready = 1'b1; ckey = 4'b1111;
    repeat (16) @(negedge clk);
    overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
    evt_ready = 1'b0; ckey = 4'b1110;
    repeat (15) @(negedge clk);
    ckey = 4'b1100;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL overrun_model c=%0d actual=%h required=%h", c, obs, exp_obs);
      end
    end
    checks++;
    if ({evt_valid, evt_data, evt_mask, overrun} !== 10'b1_0001_0001_1) begin
      errors++; $display("FAIL overrun_first actual=%b required=%b", {evt_valid, evt_data, evt_mask, overrun}, 10'b1_0001_0001_1);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL overrun_accept actual=%b required=0", evt_valid);
    end
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      seen = evt_valid;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL overrun_second_timeout actual=0 required=1");
    end else if ({evt_data, evt_mask} !== 8'b0011_0010) begin
      errors++; $display("FAIL overrun_second actual=%b required=%b", {evt_data, evt_mask}, 8'b0011_0010);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear actual=%b required=0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [W-1:0] exp_sw;
    evt_ready = 1'b0; ckey = 4'b0111;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = evt_valid;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rstmid_pending_timeout actual=0 required=1");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({evt_valid, sw_state} !== 5'b0) begin
      errors++; $display("FAIL rstmid_async actual=%b required=%b", {evt_valid, sw_state}, 5'b0);
    end
    @(negedge clk);
    rst = 1'b0; evt_ready = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      exp_sw = (e >= 11) ? 4'b1000 : 4'b0000;
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL rstmid_model edge=%0d actual=%h required=%h", e, obs, exp_obs);
      end
      checks++;
      if (sw_state !== exp_sw) begin
        errors++; $display("FAIL rstmid_sw edge=%0d actual=%b required=%b", e, sw_state, exp_sw);
      end
      if (e == 12) begin
        checks++;
        if ({evt_valid, evt_mask} !== 5'b1_1000) begin
          errors++; $display("FAIL rstmid_event actual=%b required=%b", {evt_valid, evt_mask}, 5'b1_1000);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_obs) begin
        errors++; $display("FAIL random_model cycle=%0d actual=%h required=%h", c, obs, exp_obs);
      end
      if (hold == 0) begin
        ckey = ($urandom_range(0, 1) == 0) ? W'($urandom) : (ckey ^ (W'(1) << $urandom_range(0, W - 1)));
        hold = $urandom_range(1, 16);
      end else begin
        hold--;
      end
      evt_ready   = ($urandom_range(0, 2) != 0);
      overrun_clr = ($urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
